vga_graph: RTL and testbench

- Rasterises a closed tour over 64 points into three 256x256 colour planes (R, G, B, 16 bits per pixel) that feed the VGA output stage.
- After reset it draws line segments path[0]→path[1]→…→path[63]→path[0] using Bresenham, one pixel per clock.
- It then marks every point in red and raises done.
- Point coordinates and tour order are driven by the solver upstream.

---
 rtl/vga_graph_pkg.sv | 29 ++
 rtl/vga_graph_step.sv | 52 +++++
 rtl/vga_graph.sv | 167 ++++++++++++++++
 tb/tb_vga_graph.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_graph_pkg.sv
// vga_graph_pkg: shared types and constants for the tour rasteriser.
//   NPTS / DIM / PIXW  : point count, framebuffer edge length, bits per channel
//   COL_WHITE/BLACK    : channel values for line pixels and background
//   state_t            : drawing FSM states
//   coord_t / idx_t    : 8-bit screen coordinate, 6-bit point index
//   err_t              : 10-bit signed Bresenham error / delta
package vga_graph_pkg;

   localparam int NPTS = 64;
   localparam int DIM  = 256;
   localparam int PIXW = 16;

   localparam logic [PIXW-1:0] COL_WHITE = 16'hFFFF;
   localparam logic [PIXW-1:0] COL_BLACK = 16'h0000;

   typedef enum logic [1:0] {SEG_INIT, SEG_STEP, POINT, DONE} state_t;

   typedef logic [7:0]        coord_t;
   typedef logic [5:0]        idx_t;
   typedef logic signed [9:0] err_t;

   // |a-b| widened to the signed error width (always non-negative, <= 255)
   function automatic err_t abs_diff(input coord_t a, input coord_t b);
      coord_t d;
      d = (a > b) ? (a - b) : (b - a);
      return err_t'({2'b00, d});
   endfunction

endpackage

// File: rtl/vga_graph_step.sv
// bresenham_step: combinational single-pixel advance of a Bresenham walk.
//   cur_x/cur_y   : pixel being plotted this cycle
//   end_x/end_y   : segment end point
//   err, dx, dy   : running error and deltas (dx >= 0, dy <= 0)
//   sx_neg/sy_neg : step direction per axis (1 = decrement)
//   nxt_x/nxt_y/nxt_err : state for the following pixel
//   at_end        : current pixel is the segment end point
module bresenham_step
   import vga_graph_pkg::*;
(
   input  coord_t     cur_x,
   input  coord_t     cur_y,
   input  coord_t     end_x,
   input  coord_t     end_y,
   input  err_t       err,
   input  err_t       dx,
   input  err_t       dy,
   input  logic       sx_neg,
   input  logic       sy_neg,
   output coord_t     nxt_x,
   output coord_t     nxt_y,
   output err_t       nxt_err,
   output logic       at_end
);

   logic signed [10:0] e2;
   logic signed [10:0] dx_w;
   logic signed [10:0] dy_w;

   assign e2   = {err, 1'b0};
   assign dx_w = {dx[9], dx};
   assign dy_w = {dy[9], dy};

   assign at_end = (cur_x == end_x) && (cur_y == end_y);

   // Both tests use e2 from the old error, so a diagonal step applies
   // both corrections in the same cycle.
   always_comb begin
      nxt_x   = cur_x;
      nxt_y   = cur_y;
      nxt_err = err;
      if (e2 >= dy_w) begin
         nxt_err = nxt_err + dy;
         nxt_x   = sx_neg ? (cur_x - 8'd1) : (cur_x + 8'd1);
      end
      if (e2 <= dx_w) begin
         nxt_err = nxt_err + dx;
         nxt_y   = sy_neg ? (cur_y - 8'd1) : (cur_y + 8'd1);
      end
   end

endmodule

// File: rtl/vga_graph.sv
// vga_graph: draws the closed tour path[0]->...->path[63]->path[0] into
// three 256x256 colour planes one pixel per clock, then marks every point
// red and raises done.
//   clk       : system clock
//   rst       : synchronous active-low reset; clears all planes in one cycle
//   xs, ys    : point coordinates (held stable until done)
//   path      : tour order, path[i] = point index visited i-th
//   R, G, B   : colour planes, indexed [y][x]
//   done      : drawing complete
module vga_graph
   import vga_graph_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  coord_t [NPTS-1:0]   xs,
   input  coord_t [NPTS-1:0]   ys,
   input  idx_t   [NPTS-1:0]   path,
   output logic   [PIXW-1:0]   R [DIM-1:0][DIM-1:0],
   output logic   [PIXW-1:0]   G [DIM-1:0][DIM-1:0],
   output logic   [PIXW-1:0]   B [DIM-1:0][DIM-1:0],
   output logic                done
);

   state_t state_reg;
   idx_t   seg_reg;
   idx_t   k_reg;
   coord_t cur_x_reg, cur_y_reg;
   coord_t end_x_reg, end_y_reg;
   err_t   err_reg, dx_reg, dy_reg;
   logic   sx_neg_reg, sy_neg_reg;
   logic   done_reg;

   // Segment endpoints; the 6-bit add wraps seg 63 back to path[0].
   idx_t   seg_next;
   idx_t   pa, pb;
   coord_t ax, ay, bx, by;
   err_t   init_dx, init_dy, init_err;

   assign seg_next = seg_reg + 6'd1;
   assign pa       = path[seg_reg];
   assign pb       = path[seg_next];
   assign ax       = xs[pa];
   assign ay       = ys[pa];
   assign bx       = xs[pb];
   assign by       = ys[pb];
   assign init_dx  = abs_diff(ax, bx);
   assign init_dy  = -abs_diff(ay, by);
   assign init_err = init_dx + init_dy;

   coord_t step_x, step_y;
   err_t   step_err;
   logic   step_at_end;

   bresenham_step u_step (
      .cur_x   (cur_x_reg),
      .cur_y   (cur_y_reg),
      .end_x   (end_x_reg),
      .end_y   (end_y_reg),
      .err     (err_reg),
      .dx      (dx_reg),
      .dy      (dy_reg),
      .sx_neg  (sx_neg_reg),
      .sy_neg  (sy_neg_reg),
      .nxt_x   (step_x),
      .nxt_y   (step_y),
      .nxt_err (step_err),
      .at_end  (step_at_end)
   );

   // Single framebuffer write port: white while stepping, red while
   // marking points.
   logic   wr_en;
   logic   wr_red;
   coord_t wr_x, wr_y;

   always_comb begin
      wr_en  = 1'b0;
      wr_red = 1'b0;
      wr_x   = cur_x_reg;
      wr_y   = cur_y_reg;
      case (state_reg)
         SEG_STEP: wr_en = 1'b1;
         POINT: begin
            wr_en  = 1'b1;
            wr_red = 1'b1;
            wr_x   = xs[k_reg];
            wr_y   = ys[k_reg];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int y = 0; y < DIM; y++) begin
            for (int x = 0; x < DIM; x++) begin
               R[y][x] <= COL_BLACK;
               G[y][x] <= COL_BLACK;
               B[y][x] <= COL_BLACK;
            end
         end
      end else if (wr_en) begin
         R[wr_y][wr_x] <= COL_WHITE;
         G[wr_y][wr_x] <= wr_red ? COL_BLACK : COL_WHITE;
         B[wr_y][wr_x] <= wr_red ? COL_BLACK : COL_WHITE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= SEG_INIT;
         seg_reg    <= '0;
         k_reg      <= '0;
         cur_x_reg  <= '0;
         cur_y_reg  <= '0;
         end_x_reg  <= '0;
         end_y_reg  <= '0;
         err_reg    <= '0;
         dx_reg     <= '0;
         dy_reg     <= '0;
         sx_neg_reg <= 1'b0;
         sy_neg_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            SEG_INIT: begin
               cur_x_reg  <= ax;
               cur_y_reg  <= ay;
               end_x_reg  <= bx;
               end_y_reg  <= by;
               dx_reg     <= init_dx;
               dy_reg     <= init_dy;
               err_reg    <= init_err;
               sx_neg_reg <= !(ax < bx);
               sy_neg_reg <= !(ay < by);
               state_reg  <= SEG_STEP;
            end
            SEG_STEP: begin
               if (step_at_end) begin
                  if (seg_reg == idx_t'(NPTS - 1)) begin
                     k_reg     <= '0;
                     state_reg <= POINT;
                  end else begin
                     seg_reg   <= seg_next;
                     state_reg <= SEG_INIT;
                  end
               end else begin
                  cur_x_reg <= step_x;
                  cur_y_reg <= step_y;
                  err_reg   <= step_err;
               end
            end
            POINT: begin
               k_reg <= k_reg + 6'd1;
               if (k_reg == idx_t'(NPTS - 1)) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            default: done_reg <= 1'b1;
         endcase
      end
   end

   assign done = done_reg;

endmodule

// File: tb/tb_vga_graph.sv
module tb_vga_graph;
   import vga_graph_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   coord_t [NPTS-1:0]   xs;
   coord_t [NPTS-1:0]   ys;
   idx_t   [NPTS-1:0]   path;
   logic   [PIXW-1:0]   R [DIM-1:0][DIM-1:0];
   logic   [PIXW-1:0]   G [DIM-1:0][DIM-1:0];
   logic   [PIXW-1:0]   B [DIM-1:0][DIM-1:0];
   logic                done;

   vga_graph dut (
      .clk  (clk),
      .rst  (rst),
      .xs   (xs),
      .ys   (ys),
      .path (path),
      .R    (R),
      .G    (G),
      .B    (B),
      .done (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference image: 0 black, 1 white, 2 red
   byte unsigned expf [256][256];
   int           exp_cycles;
   int           seg_start [64];
   int           meas_cycles;

   typedef enum int {K_RECT, K_FRAME, K_ZERO, K_CYCLES, K_DONE} kind_t;

   typedef struct {
      string name;
      kind_t kind;
      int    y0, x0, y1, x1;
      int    code;
      int    req;
   } exp_t;

   exp_t sb [$];

   typedef struct {
      int    pat;
      string name;
      int    y0, x0, y1, x1;
      int    code;
      int    cnt;   // 0: every pixel of the rectangle must have code
   } vec_t;

   vec_t vecs [11];

   function automatic int pix_code(int y, int x);
      if (R[y][x] == 16'h0000 && G[y][x] == 16'h0000 && B[y][x] == 16'h0000) return 0;
      if (R[y][x] == 16'hFFFF && G[y][x] == 16'hFFFF && B[y][x] == 16'hFFFF) return 1;
      if (R[y][x] == 16'hFFFF && G[y][x] == 16'h0000 && B[y][x] == 16'h0000) return 2;
      return 3;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: actual %0d, required %0d", name, act, req);
   endtask

   task automatic load_pattern(input int pat);
      for (int i = 0; i < NPTS; i++) begin
         path[i] = idx_t'(i);
         case (pat)
            0: begin xs[i] = coord_t'((32 * i) % 256); ys[i] = coord_t'((27 * i) % 256); end
            1: begin xs[i] = (i == 1) ? 8'd20 : 8'd10; ys[i] = 8'd10; end
            2: begin xs[i] = 8'd5; ys[i] = 8'd5; end
            default: begin
               path[i] = idx_t'(63 - i);
               if (i == 0)       begin xs[i] = 8'd0;   ys[i] = 8'd0;   end
               else if (i == 63) begin xs[i] = 8'd0;   ys[i] = 8'd100; end
               else              begin xs[i] = 8'd200; ys[i] = 8'd200; end
            end
         endcase
      end
   endtask

   // Textbook Bresenham over the tour, then the red points; also counts
   // clock edges from reset release to done.
   task automatic model_run();
      int cyc, a, b, x0, y0, x1, y1, dx, dy, sx, sy, err, e2;
      for (int y = 0; y < 256; y++)
         for (int x = 0; x < 256; x++)
            expf[y][x] = 0;
      cyc = 0;
      for (int s = 0; s < NPTS; s++) begin
         seg_start[s] = cyc;
         a  = int'(path[s]);
         b  = int'(path[(s + 1) % NPTS]);
         x0 = int'(xs[a]); y0 = int'(ys[a]);
         x1 = int'(xs[b]); y1 = int'(ys[b]);
         dx = (x1 > x0) ? x1 - x0 : x0 - x1;
         dy = (y1 > y0) ? y0 - y1 : y1 - y0;
         sx = (x0 < x1) ? 1 : -1;
         sy = (y0 < y1) ? 1 : -1;
         err = dx + dy;
         cyc++;
         forever begin
            expf[y0][x0] = 1;
            cyc++;
            if (x0 == x1 && y0 == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x0 += sx; end
            if (e2 <= dx) begin err += dx; y0 += sy; end
         end
      end
      for (int k = 0; k < NPTS; k++) begin
         expf[ys[k]][xs[k]] = 2;
         cyc++;
      end
      exp_cycles = cyc;
   endtask

   task automatic push(input string name, input kind_t kind, input int y0, input int x0,
                       input int y1, input int x1, input int code, input int req);
      exp_t e;
      e.name = name; e.kind = kind;
      e.y0 = y0; e.x0 = x0; e.y1 = y1; e.x1 = x1;
      e.code = code; e.req = req;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      int   cnt;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cnt = 0;
         case (e.kind)
            K_RECT: begin
               for (int y = e.y0; y <= e.y1; y++)
                  for (int x = e.x0; x <= e.x1; x++)
                     if (pix_code(y, x) == e.code) cnt++;
               check(e.name, cnt, e.req);
            end
            K_FRAME: begin
               for (int y = 0; y < 256; y++)
                  for (int x = 0; x < 256; x++)
                     if (pix_code(y, x) != int'(expf[y][x])) cnt++;
               check(e.name, cnt, e.req);
            end
            K_ZERO: begin
               for (int y = 0; y < 256; y++)
                  for (int x = 0; x < 256; x++)
                     if (pix_code(y, x) != 0) cnt++;
               check(e.name, cnt, e.req);
            end
            K_CYCLES: check(e.name, meas_cycles, e.req);
            default:  check(e.name, int'(done), e.req);
         endcase
      end
   endtask

   task automatic start_pattern(input int pat);
      load_pattern(pat);
      model_run();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic reset_check(input string tag);
      rst = 1'b0;
      @(posedge clk); #1;
      push({tag, "_planes_zero"}, K_ZERO, 0, 0, 0, 0, 0, 0);
      push({tag, "_done_low"}, K_DONE, 0, 0, 0, 0, 0, 0);
      drain();
   endtask

   // Expects rst to have been released just after the previous edge.
   task automatic finish_run(input string tag, input int pat, input int limit);
      int area;
      foreach (vecs[i]) begin
         if (vecs[i].pat == pat) begin
            area = (vecs[i].y1 - vecs[i].y0 + 1) * (vecs[i].x1 - vecs[i].x0 + 1);
            push(vecs[i].name, K_RECT, vecs[i].y0, vecs[i].x0, vecs[i].y1, vecs[i].x1,
                 vecs[i].code, (vecs[i].cnt == 0) ? area : vecs[i].cnt);
         end
      end
      push({tag, "_done_cycles"}, K_CYCLES, 0, 0, 0, 0, 0, exp_cycles);
      push({tag, "_frame"}, K_FRAME, 0, 0, 0, 0, 0, 0);
      push({tag, "_done_held"}, K_DONE, 0, 0, 0, 0, 0, 1);
      meas_cycles = 0;
      while (!done && meas_cycles < limit) begin
         @(posedge clk); #1;
         meas_cycles++;
      end
      repeat (5) @(posedge clk);
      #1;
      drain();
      $display("run %s: done after %0d cycles (model %0d)", tag, meas_cycles, exp_cycles);
   endtask

   initial begin
      vecs[0]  = '{0, "std_p1_red",          27, 32,  27,  32,  2, 0};
      vecs[1]  = '{0, "std_p0_red",           0,  0,   0,   0,  2, 0};
      vecs[2]  = '{0, "std_x16_one_white",   13, 16,  14,  16,  1, 1};
      vecs[3]  = '{0, "std_y255_x128_black", 255, 128, 255, 128, 0, 0};
      vecs[4]  = '{1, "hz_row10_white",      10, 11,  10,  19,  1, 0};
      vecs[5]  = '{1, "hz_x10_red",          10, 10,  10,  10,  2, 0};
      vecs[6]  = '{1, "hz_x20_red",          10, 20,  10,  20,  2, 0};
      vecs[7]  = '{1, "hz_row11_black",      11,  0,  11, 255,  0, 0};
      vecs[8]  = '{2, "dg_p_red",             5,  5,   5,   5,  2, 0};
      vecs[9]  = '{2, "dg_black_count",       0,  0, 255, 255,  0, 65535};
      vecs[10] = '{3, "cl_col0_white",        1,  0,  99,   0,  1, 0};

      // Standard pattern, then reset from a fully drawn state
      start_pattern(0);
      finish_run("std", 0, 70000);
      reset_check("rst_after_std");

      // Reset while stepping segment 5, then redraw from scratch
      start_pattern(0);
      repeat (seg_start[5] + 2) @(posedge clk);
      #1;
      reset_check("rst_mid_draw");
      rst = 1'b1;
      finish_run("std_after_mid_rst", 0, 70000);

      start_pattern(1);
      finish_run("horiz", 1, 70000);

      start_pattern(2);
      finish_run("degen", 2, 200);

      start_pattern(3);
      finish_run("closing", 3, 70000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
